sd_out_ddr_buf: RTL and testbench

- Buffered SDR-to-DDR output closure block. Accepts full-width words on an SDR srdy/drdy interface and presents each word as two half-width DDR phases on the producer interface.
- Adds a parametrised-depth elastic FIFO and a registered c_drdy, so there is no combinational path from p_drdy to c_drdy.
- Adds selectable idle-pattern modes and an occupancy output.
- Sits at the chip-edge output boundary, between core srdy/drdy logic and the DDR pad ring.

---
 rtl/sd_out_ddr_buf_pkg.sv | 15 +
 rtl/sd_ddr_buf_mem.sv | 32 +++
 rtl/sd_out_ddr_buf.sv | 125 ++++++++++++
 tb/tb_sd_out_ddr_buf.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sd_out_ddr_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sd_out_ddr_buf_pkg
//  Brief    : Shared encodings for the SDR-to-DDR output buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package sd_out_ddr_buf_pkg;

    // Idle pattern modes, selecting what p_data shows when no word is presented
    localparam int SDDDR_IDLE_ZERO   = 0;
    localparam int SDDDR_IDLE_REPEAT = 1;
    localparam int SDDDR_IDLE_VALUE  = 2;

endpackage : sd_out_ddr_buf_pkg
`default_nettype wire

// File: rtl/sd_ddr_buf_mem.sv
`default_nettype none
// ============================================================================
//  Module   : sd_ddr_buf_mem
//  Brief    : DEPTH x WIDTH register file, synchronous write, async read.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_ddr_buf_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int ASZ   = 2
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [ASZ-1:0]   i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [ASZ-1:0]   i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Storage has no reset: validity is tracked by the pointers and usage count
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : sd_ddr_buf_mem
`default_nettype wire

// File: rtl/sd_out_ddr_buf.sv
`default_nettype none
// ============================================================================
//  Module   : sd_out_ddr_buf
//  Brief    : Buffered SDR-to-DDR output stage. Full-width words enter an
//             elastic FIFO, move into an output hold register and are driven
//             as two half-width phases (high half while clk is high).
//  Revision : 1.0 - initial release
// ============================================================================
module sd_out_ddr_buf
    import sd_out_ddr_buf_pkg::*;
#(
    parameter int                  WIDTH      = 8,
    parameter int                  DEPTH      = 4,
    parameter int                  ASZ        = 2,
    parameter int                  IDLE_MODE  = SDDDR_IDLE_REPEAT,
    parameter logic [WIDTH/2-1:0]  IDLE_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               c_srdy,
    output logic               c_drdy,
    input  logic [WIDTH-1:0]   c_data,
    output logic               p_srdy,
    input  logic               p_drdy,
    output logic [WIDTH/2-1:0] p_data,
    output logic [ASZ:0]       usage
);

    localparam int           c_HALF = WIDTH / 2;
    localparam logic [ASZ:0] c_FULL = (ASZ+1)'(DEPTH);

    logic [ASZ-1:0]   r_wr_ptr;
    logic [ASZ-1:0]   r_rd_ptr;
    logic [ASZ:0]     r_usage;
    logic             r_c_drdy;
    logic             r_p_srdy;
    logic [WIDTH-1:0] r_hold;
    logic [c_HALF-1:0] r_last_low;

    logic             w_write;
    logic             w_load;
    logic [ASZ:0]     w_usage_nxt;
    logic             w_p_srdy_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic [WIDTH-1:0] w_head;
    logic [c_HALF-1:0] w_last_low_nxt;
    logic [c_HALF-1:0] w_idle_half;

    sd_ddr_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ASZ   (ASZ)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_write),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (c_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    assign w_write = c_srdy & r_c_drdy;
    assign w_load  = (r_usage != '0) & (~r_p_srdy | p_drdy);

    // A word leaving the hold register this edge becomes the repeat source,
    // so the idle pattern formed on the same edge already reflects it.
    assign w_last_low_nxt = (r_p_srdy & p_drdy) ? r_hold[c_HALF-1:0] : r_last_low;

    if (IDLE_MODE == SDDDR_IDLE_REPEAT) begin : g_idle_repeat
        assign w_idle_half = w_last_low_nxt;
    end else if (IDLE_MODE == SDDDR_IDLE_VALUE) begin : g_idle_value
        assign w_idle_half = IDLE_VALUE;
    end else begin : g_idle_zero
        assign w_idle_half = '0;
    end

    // Next occupancy, output valid and hold contents
    always_comb begin
        w_usage_nxt  = r_usage + {{ASZ{1'b0}}, w_write} - {{ASZ{1'b0}}, w_load};
        w_p_srdy_nxt = r_p_srdy;
        w_hold_nxt   = r_hold;
        if (w_load) begin
            w_p_srdy_nxt = 1'b1;
        end else if (p_drdy) begin
            w_p_srdy_nxt = 1'b0;
        end
        if (w_load) begin
            w_hold_nxt = w_head;
        end else if (!w_p_srdy_nxt) begin
            w_hold_nxt = {2{w_idle_half}};
        end
    end

    // Pointer, occupancy and handshake state; reset drops everything at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_usage    <= '0;
            r_c_drdy   <= 1'b0;
            r_p_srdy   <= 1'b0;
            r_hold     <= '0;
            r_last_low <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + ASZ'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + ASZ'(1);
            end
            r_usage    <= w_usage_nxt;
            r_c_drdy   <= (w_usage_nxt < c_FULL);
            r_p_srdy   <= w_p_srdy_nxt;
            r_hold     <= w_hold_nxt;
            r_last_low <= w_last_low_nxt;
        end
    end

    assign c_drdy = r_c_drdy;
    assign p_srdy = r_p_srdy;
    assign usage  = r_usage;
    assign p_data = clk ? r_hold[WIDTH-1:c_HALF] : r_hold[c_HALF-1:0];

endmodule : sd_out_ddr_buf
`default_nettype wire

// File: tb/tb_sd_out_ddr_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_out_ddr_buf
//  Brief    : Directed self-checking bench, WIDTH=8 DEPTH=4, three idle modes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_out_ddr_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       c_srdy;
    logic [7:0] c_data;
    logic       p_drdy;

    logic       c_drdy1, p_srdy1, c_drdy2, p_srdy2, c_drdy0, p_srdy0;
    logic [3:0] p_data1, p_data2, p_data0;
    logic [2:0] usage1, usage2, usage0;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] r_words [5];
    logic [2:0] r_exp_u [5];

    always #5 clk = ~clk;

    sd_out_ddr_buf #(.WIDTH(8), .DEPTH(4), .ASZ(2), .IDLE_MODE(1), .IDLE_VALUE(4'h0)) u_dut1 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy1), .c_data(c_data),
        .p_srdy(p_srdy1), .p_drdy(p_drdy), .p_data(p_data1), .usage(usage1));

    sd_out_ddr_buf #(.WIDTH(8), .DEPTH(4), .ASZ(2), .IDLE_MODE(2), .IDLE_VALUE(4'h9)) u_dut2 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy2), .c_data(c_data),
        .p_srdy(p_srdy2), .p_drdy(p_drdy), .p_data(p_data2), .usage(usage2));

    sd_out_ddr_buf #(.WIDTH(8), .DEPTH(4), .ASZ(2), .IDLE_MODE(0), .IDLE_VALUE(4'h0)) u_dut0 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy0), .c_data(c_data),
        .p_srdy(p_srdy0), .p_drdy(p_drdy), .p_data(p_data0), .usage(usage0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
        #1;
    endtask

    initial begin
        r_words[0] = 8'h11; r_words[1] = 8'h22; r_words[2] = 8'h33;
        r_words[3] = 8'h44; r_words[4] = 8'h55;
        r_exp_u[0] = 3'd1;  r_exp_u[1] = 3'd1;  r_exp_u[2] = 3'd2;
        r_exp_u[3] = 3'd3;  r_exp_u[4] = 3'd4;

        reset  = 1'b0;
        c_srdy = 1'b0;
        c_data = 8'h00;
        p_drdy = 1'b1;
        #1 reset = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_c_drdy", c_drdy1, 0);
        chk("rst_p_srdy", p_srdy1, 0);
        chk("rst_usage",  usage1, 0);
        chk("rst_pdata_hi", p_data1, 0);
        chk("rst_pdata_hi_m2", p_data2, 0);
        half();
        chk("rst_pdata_lo", p_data1, 0);

        // Release: c_drdy stays low until the first edge
        reset = 1'b0;
        #1;
        chk("c_drdy_pre_edge", c_drdy1, 0);
        tick();
        chk("c_drdy_post_edge", c_drdy1, 1);
        chk("idle_p_srdy", p_srdy1, 0);
        chk("idle_m1_hi", p_data1, 4'h0);
        chk("idle_m2_hi", p_data2, 4'h9);
        chk("idle_m0_hi", p_data0, 4'h0);
        half();
        chk("idle_m1_lo", p_data1, 4'h0);
        chk("idle_m2_lo", p_data2, 4'h9);

        // Single word 0xA5 with p_drdy high
        c_srdy = 1'b1; c_data = 8'hA5;
        tick();
        c_srdy = 1'b0;
        chk("single_usage_acc", usage1, 1);
        chk("single_p_srdy_acc", p_srdy1, 0);
        tick();
        chk("single_p_srdy", p_srdy1, 1);
        chk("single_hi", p_data1, 4'hA);
        chk("single_usage", usage1, 0);
        half();
        chk("single_lo", p_data1, 4'h5);
        tick();
        chk("single_done_p_srdy", p_srdy1, 0);
        chk("repeat_hi", p_data1, 4'h5);
        chk("value_hi", p_data2, 4'h9);
        chk("zero_hi", p_data0, 4'h0);
        half();
        chk("repeat_lo", p_data1, 4'h5);
        chk("value_lo", p_data2, 4'h9);
        chk("zero_lo", p_data0, 4'h0);

        // Back-pressure: fill FIFO behind a stalled hold register
        p_drdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c_srdy = 1'b1; c_data = r_words[i];
            tick();
            chk($sformatf("fill_usage%0d", i), usage1, r_exp_u[i]);
        end
        chk("full_c_drdy", c_drdy1, 0);
        chk("full_p_srdy", p_srdy1, 1);
        chk("full_hold_hi", p_data1, 4'h1);
        c_data = 8'h66;
        tick(); tick();
        chk("full_no_accept_usage", usage1, 4);
        chk("full_no_accept_c_drdy", c_drdy1, 0);
        chk("full_hold_stable", p_data1, 4'h1);
        half();
        chk("full_hold_lo", p_data1, 4'h1);

        // Drain with p_drdy continuously high
        c_srdy = 1'b0; p_drdy = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("drain_p_srdy%0d", i), p_srdy1, 1);
            chk($sformatf("drain_hi%0d", i), p_data1, {28'd0, r_words[i][7:4]});
            chk($sformatf("drain_usage%0d", i), usage1, 3'(4 - i));
            if (i == 1) chk("drain_c_drdy_rise", c_drdy1, 1);
            half();
            chk($sformatf("drain_lo%0d", i), p_data1, {28'd0, r_words[i][3:0]});
        end
        tick();
        chk("drained_p_srdy", p_srdy1, 0);
        chk("drained_usage", usage1, 0);
        chk("drained_m1_hi", p_data1, 4'h5);
        chk("drained_m2_hi", p_data2, 4'h9);
        chk("drained_m0_hi", p_data0, 4'h0);
        half();
        chk("drained_m1_lo", p_data1, 4'h5);
        chk("drained_m2_lo", p_data2, 4'h9);

        // Reset mid-transfer with usage=3 and p_srdy=1
        p_drdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c_srdy = 1'b1; c_data = 8'hC1 + 8'(i);
            tick();
        end
        c_srdy = 1'b0;
        chk("pre_rst_usage", usage1, 3);
        chk("pre_rst_p_srdy", p_srdy1, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_p_srdy", p_srdy1, 0);
        chk("async_rst_usage", usage1, 0);
        chk("async_rst_c_drdy", c_drdy1, 0);
        chk("async_rst_pdata", p_data1, 0);
        tick();
        reset = 1'b0; p_drdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_p_srdy%0d", i), p_srdy1, 0);
            chk($sformatf("post_rst_usage%0d", i), usage1, 0);
            chk($sformatf("post_rst_hi%0d", i), p_data1, 0);
            half();
            chk($sformatf("post_rst_lo%0d", i), p_data1, 0);
        end
        chk("post_rst_c_drdy", c_drdy1, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_sd_out_ddr_buf
`default_nettype wire
